// File: rtl/pwm_multi_button.sv
// Multi-channel button-controlled PWM: debounced buttons with auto-repeat, shadowed
// per-channel duty and shared prescaler, both applied only at PWM period boundaries.
module pwm_multi_button #(
  parameter int CHANNELS    = 4,
  parameter int DB_BITS     = 4,
  parameter int DUTY_W      = 8,
  parameter int PRE_W       = 8,
  parameter int DUTY_STEP   = 1,
  parameter int REP_BITS    = 6,
  parameter int AUTO_REPEAT = 1,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_duty_bt,
  input  logic                dec_duty_bt,
  input  logic                inc_freq_bt,
  input  logic                dec_freq_bt,
  input  logic                ch_sel_bt,
  output logic [SEL_W-1:0]    sel_ch,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam int NB = 5;
  localparam int B_INC_DUTY = 0;
  localparam int B_DEC_DUTY = 1;
  localparam int B_INC_FREQ = 2;
  localparam int B_DEC_FREQ = 3;
  localparam int B_CH_SEL   = 4;

  localparam logic [DUTY_W:0]  STEP_X    = (DUTY_W+1)'(DUTY_STEP);
  localparam logic [DUTY_W:0]  DUTY_MAX  = {1'b0, {DUTY_W{1'b1}}};
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [PRE_W-1:0] DIV_MAX   = {PRE_W{1'b1}};

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] strobe;

  assign btn_raw = {ch_sel_bt, dec_freq_bt, inc_freq_bt, dec_duty_bt, inc_duty_bt};

  // Per-button synchroniser, debounce and (for the duty/freq buttons) auto-repeat.
  for (genvar gi = 0; gi < NB; gi++) begin : g_btn
    localparam bit REP_EN = (AUTO_REPEAT != 0) && (gi != B_CH_SEL);

    logic                sync1_reg;
    logic                sync2_reg;
    logic                stable_reg;
    logic [DB_BITS-1:0]  db_cnt_reg;
    logic [REP_BITS-1:0] rep_cnt_reg;
    logic                strobe_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_reg   <= 1'b0;
        sync2_reg   <= 1'b0;
        stable_reg  <= 1'b0;
        db_cnt_reg  <= '0;
        rep_cnt_reg <= '0;
        strobe_reg  <= 1'b0;
      end else begin
        sync1_reg  <= btn_raw[gi];
        sync2_reg  <= sync1_reg;
        strobe_reg <= 1'b0;
        if (sync2_reg != stable_reg) begin
          if (db_cnt_reg == {DB_BITS{1'b1}}) begin
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
            if (sync2_reg)
              strobe_reg <= 1'b1;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end else begin
          db_cnt_reg <= '0;
        end
        // Repeat fires on the wrap, i.e. 2^REP_BITS cycles after the press strobe.
        if (REP_EN && stable_reg) begin
          rep_cnt_reg <= rep_cnt_reg + 1'b1;
          if (rep_cnt_reg == {REP_BITS{1'b1}})
            strobe_reg <= 1'b1;
        end else begin
          rep_cnt_reg <= '0;
        end
      end
    end

    assign strobe[gi] = strobe_reg;
  end

  logic             duty_wr;
  logic             duty_up;
  logic             div_wr;
  logic [SEL_W-1:0] sel_ch_reg;
  logic [PRE_W-1:0] shadow_div_reg;
  logic [PRE_W-1:0] active_div_reg;
  logic [PRE_W-1:0] pre_reg;
  logic [DUTY_W-1:0] pwm_cnt_reg;
  logic             tick;
  logic             boundary;

  // Opposing strobes in the same cycle cancel out.
  assign duty_wr = strobe[B_INC_DUTY] ^ strobe[B_DEC_DUTY];
  assign duty_up = strobe[B_INC_DUTY];
  assign div_wr  = strobe[B_INC_FREQ] ^ strobe[B_DEC_FREQ];

  assign tick     = (pre_reg == active_div_reg);
  assign boundary = tick && (pwm_cnt_reg == {DUTY_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_ch_reg     <= '0;
      shadow_div_reg <= '0;
      active_div_reg <= '0;
      pre_reg        <= '0;
      pwm_cnt_reg    <= '0;
    end else begin
      if (strobe[B_CH_SEL])
        sel_ch_reg <= (sel_ch_reg == SEL_LAST) ? '0 : sel_ch_reg + 1'b1;
      if (div_wr) begin
        if (strobe[B_INC_FREQ])
          shadow_div_reg <= (shadow_div_reg == '0) ? '0 : shadow_div_reg - 1'b1;
        else
          shadow_div_reg <= (shadow_div_reg == DIV_MAX) ? DIV_MAX : shadow_div_reg + 1'b1;
      end
      pre_reg <= tick ? '0 : pre_reg + 1'b1;
      if (tick)
        pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      if (boundary)
        active_div_reg <= shadow_div_reg;
    end
  end

  assign sel_ch = sel_ch_reg;

  function automatic logic [DUTY_W-1:0] sat_step(input logic [DUTY_W-1:0] d, input logic up);
    logic [DUTY_W:0] dx;
    logic [DUTY_W:0] sum;
    dx  = {1'b0, d};
    sum = dx + STEP_X;
    if (up)
      sat_step = (sum > DUTY_MAX) ? DUTY_MAX[DUTY_W-1:0] : sum[DUTY_W-1:0];
    else
      sat_step = (dx < STEP_X) ? '0 : d - STEP_X[DUTY_W-1:0];
  endfunction

  // Per-channel shadow/active duty and registered comparator output.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(gi);

    logic [DUTY_W-1:0] shadow_duty_reg;
    logic [DUTY_W-1:0] active_duty_reg;
    logic              out_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shadow_duty_reg <= '0;
        active_duty_reg <= '0;
        out_reg         <= 1'b0;
      end else begin
        if (duty_wr && (sel_ch_reg == CH_IDX))
          shadow_duty_reg <= sat_step(shadow_duty_reg, duty_up);
        if (boundary)
          active_duty_reg <= shadow_duty_reg;
        out_reg <= (pwm_cnt_reg < active_duty_reg);
      end
    end

    assign pwm_out[gi] = out_reg;
  end

endmodule

// File: tb/tb_pwm_multi_button.sv
// Directed bench for pwm_multi_button: a table of button presses with expected
// selection and duty, plus hand sequences for bounce, frequency and reset.
module tb_pwm_multi_button;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = 5'b0;  // {ch_sel, dec_freq, inc_freq, dec_duty, inc_duty}
  logic [1:0] sel_ch;
  logic [3:0] pwm_out;

  int checks = 0;
  int passes = 0;

  pwm_multi_button #(
    .CHANNELS(4), .DB_BITS(2), .DUTY_W(4), .PRE_W(4),
    .DUTY_STEP(2), .REP_BITS(4), .AUTO_REPEAT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inc_duty_bt(btn[0]),
    .dec_duty_bt(btn[1]),
    .inc_freq_bt(btn[2]),
    .dec_freq_bt(btn[3]),
    .ch_sel_bt(btn[4]),
    .sel_ch(sel_ch),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    int         hold;
    int         chk_ch;
    int         exp_sel;
    int         exp_high;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
      $display("ok   %s: got %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] b, input int hold);
    btn = b;
    repeat (hold) @(posedge clk);
    #1 btn = 5'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // High cycles of one channel over a 16-cycle window (one period at div=0).
  task automatic measure_high(input int ch, output int cnt);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pwm_out[ch]) cnt++;
    end
  endtask

  // Cycles between two rising edges of pwm_out[0]; -1 if none within the bound.
  task automatic measure_period(output int p);
    logic prev;
    bit   found;
    int   cnt;
    p = -1;
    @(negedge clk);
    prev  = pwm_out[0];
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (pwm_out[0] && !prev) found = 1'b1;
      prev = pwm_out[0];
    end
    if (found) begin
      found = 1'b0;
      cnt   = 0;
      for (int i = 0; i < 400 && !found; i++) begin
        @(negedge clk);
        cnt++;
        if (pwm_out[0] && !prev) found = 1'b1;
        prev = pwm_out[0];
      end
      if (found) p = cnt;
    end
  endtask

  initial begin
    int   val;
    logic any_high;
    bit   hit;

    // btn, hold, channel checked, expected sel_ch, expected high cycles per 16
    vecs[0]  = '{5'b00001, 70, 0, 0, 12};  // 1 press + 4 repeats: 2 -> 12
    vecs[1]  = '{5'b00001, 70, 0, 0, 15};  // climbs past 15, saturates
    vecs[2]  = '{5'b00001,  8, 0, 0, 15};  // further press stays at max
    vecs[3]  = '{5'b00011,  8, 0, 0, 15};  // inc+dec together: no change
    vecs[4]  = '{5'b10000,  8, 1, 1,  0};
    vecs[5]  = '{5'b10000,  8, 2, 2,  0};
    vecs[6]  = '{5'b10000,  8, 3, 3,  0};
    vecs[7]  = '{5'b10000,  8, 0, 0, 15};  // wrap 3 -> 0
    vecs[8]  = '{5'b10000,  8, 1, 1,  0};
    vecs[9]  = '{5'b00010,  8, 1, 1,  0};  // dec at 0 saturates, no wrap
    vecs[10] = '{5'b10001,  8, 1, 2,  2};  // ch_sel+inc: duty goes to old channel
    vecs[11] = '{5'b00010,  8, 0, 2, 15};  // dec on ch2 leaves ch0 alone
    vecs[12] = '{5'b00100,  8, 0, 2, 15};  // inc_freq at div=0

    // Reset state
    rst_n = 1'b0;
    wait_cycles(3);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_sel_ch", int'(sel_ch), 0);
    rst_n = 1'b1;

    // Idle: nothing should ever go high
    any_high = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      any_high |= |pwm_out;
    end
    check("idle_pwm_out", int'(any_high), 0);
    check("idle_sel_ch", int'(sel_ch), 0);

    // Bounce: runs of 2 are rejected, then a 10-cycle hold is one press
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      btn[0] = ((i % 4) < 2);
      @(posedge clk); #1;
    end
    press(5'b00001, 10);
    wait_cycles(40);
    measure_high(0, val);
    check("bounce_ch0_high", val, 2);
    any_high = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      any_high |= |pwm_out[3:1];
    end
    check("bounce_others_low", int'(any_high), 0);

    // Table-driven presses at div=0
    for (int v = 0; v < 13; v++) begin
      @(posedge clk); #1;
      press(vecs[v].btn, vecs[v].hold);
      wait_cycles(40);
      check($sformatf("vec%0d_sel_ch", v), int'(sel_ch), vecs[v].exp_sel);
      measure_high(vecs[v].chk_ch, val);
      check($sformatf("vec%0d_ch%0d_high", v, vecs[v].chk_ch), val, vecs[v].exp_high);
    end

    // div still 0 after inc_freq at 0: 16-cycle period
    measure_period(val);
    check("period_div0", val, 16);

    // dec_freq twice -> div=2, tick every 3 cycles, period 48
    press(5'b01000, 8);
    wait_cycles(10);
    press(5'b01000, 8);
    wait_cycles(150);
    measure_period(val);
    check("period_div2", val, 48);
    measure_period(val);
    check("period_div2_again", val, 48);

    // Fresh start, build ch0 duty 8, select ch1, then reset mid-period
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press(5'b00001, 8);
      wait_cycles(10);
    end
    wait_cycles(40);
    measure_high(0, val);
    check("pre_rst_ch0_high", val, 8);
    press(5'b10000, 8);
    wait_cycles(20);
    check("pre_rst_sel_ch", int'(sel_ch), 1);

    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (pwm_out[0]) hit = 1'b1;
    end
    check("pre_rst_ch0_seen_high", int'(hit), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_pwm_out", int'(pwm_out), 0);
    check("mid_rst_sel_ch", int'(sel_ch), 0);
    rst_n = 1'b1;

    wait_cycles(40);
    measure_high(0, val);
    check("post_rst_ch0_high", val, 0);
    press(5'b00001, 8);
    wait_cycles(40);
    measure_high(0, val);
    check("post_rst_ch0_step", val, 2);
    measure_period(val);
    check("post_rst_period", val, 16);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi_button.md
Name: pwm_multi_button

Overview:
- Multi-channel, button-controlled PWM generator; next generation of the single-channel button PWM.
- Adds N channels with independent duty, a channel-select button, and auto-repeat on held buttons.
- Adds glitch-free shadowed updates applied at period boundaries, and a shared frequency prescaler.
- Sits between board push-buttons (raw, asynchronous, bouncy) and LED/motor pins.

Parameters:
- CHANNELS, 4, number of PWM outputs (1..16).
- DB_BITS, 4, debounce counter width; an input must differ from its stable state for 2^DB_BITS consecutive cycles to be accepted.
- DUTY_W, 8, duty and PWM counter width; period = 2^DUTY_W ticks.
- PRE_W, 8, prescaler divisor width.
- DUTY_STEP, 1, duty increment/decrement per accepted press.
- REP_BITS, 6, auto-repeat interval = 2^REP_BITS cycles of continuous hold.
- AUTO_REPEAT, 1, 1 = repeat enabled on the four duty/freq buttons; 0 = single pulse per press.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- inc_duty_bt, in, 1, raw button: increase duty of the selected channel.
- dec_duty_bt, in, 1, raw button: decrease duty of the selected channel.
- inc_freq_bt, in, 1, raw button: raise frequency (divisor − 1).
- dec_freq_bt, in, 1, raw button: lower frequency (divisor + 1).
- ch_sel_bt, in, 1, raw button: advance the selected channel.
- sel_ch, out, max(1,$clog2(CHANNELS)), currently selected channel.
- pwm_out, out, CHANNELS, registered PWM outputs.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all sync flops, stable states, debounce counters and repeat counters clear to 0;
  - shadow and active duty = 0; shadow and active div = 0;
  - prescaler = 0, pwm_cnt = 0, sel_ch = 0, pwm_out = 0.
- Reset mid-operation drops any in-flight press. A button still held when rst_n is released is accepted as a new press after debounce.
- Input path, per button:
  - 2-flop synchroniser, then debounce.
  - The debounce counter increments while the synchronised value differs from the stable value, and clears when they match.
  - When the counter equals 2^DB_BITS−1 and the values still differ, the stable value toggles and the counter clears.
  - A 0→1 stable transition produces a 1-cycle strobe in the same cycle.
- Auto-repeat (AUTO_REPEAT=1, duty/freq buttons only):
  - While stable=1, the repeat counter increments each cycle.
  - On wrap to 0 (every 2^REP_BITS cycles after the press strobe), another strobe is issued.
  - Counter clears when stable=0.
  - ch_sel_bt never repeats.
- Strobe effects, registered on the next edge:
  - inc_duty: shadow_duty[sel_ch] = min(duty + DUTY_STEP, 2^DUTY_W−1).
  - dec_duty: max(duty − DUTY_STEP, 0); saturating, no wrap.
  - Both duty strobes in the same cycle: no change.
  - inc_freq: shadow_div = max(div−1, 0). dec_freq: min(div+1, 2^PRE_W−1). Both in the same cycle: no change.
  - ch_sel: sel_ch increments, wrapping CHANNELS−1 → 0.
  - ch_sel in the same cycle as a duty strobe: the duty change applies to the old sel_ch.
- Timebase:
  - The prescaler counts 0..active_div. tick=1 in the cycle prescaler==active_div, and the prescaler then reloads 0. div=0 gives tick every cycle.
  - pwm_cnt (DUTY_W bits) increments on tick and wraps 2^DUTY_W−1 → 0.
- Period boundary (tick while pwm_cnt==2^DUTY_W−1): active_duty[] ← shadow_duty[], active_div ← shadow_div. The current period is never altered mid-way.
- Output: pwm_out[i] is registered as (pwm_cnt < active_duty[i]). It lags pwm_cnt by 1 cycle.
  - duty 0 → constant 0.
  - duty 2^DUTY_W−1 → low for 1 of 2^DUTY_W ticks.
- Channels share pwm_cnt, so all rising edges are aligned.

Test Plan:
Bench parameters: CHANNELS=4, DB_BITS=2, DUTY_W=4, PRE_W=4, DUTY_STEP=2, REP_BITS=4, AUTO_REPEAT=1.
- Reset, then idle 40 cycles, all buttons 0 -> pwm_out=4'b0000, sel_ch=0, tick every cycle; pwm_cnt period 16 cycles.
- Bounce: inc_duty_bt toggles 1/0 every 2 cycles for 12 cycles, then held 1 for 10 cycles and released -> exactly one strobe. After the next period boundary, pwm_out[0] is high 2 of every 16 cycles; other channels stay 0.
- Hold inc_duty_bt 70 cycles -> 1 press strobe plus repeats every 16 cycles. Duty climbs in steps of 2 and saturates at 15 (high 15 of 16). A further press leaves it at 15.
- Press ch_sel_bt 5 times -> sel_ch 1,2,3,0,1. Then press dec_duty_bt -> channel 1 stays at 0 (no wrap) and channel 0 is unchanged.
- Press dec_freq_bt twice (div=2) -> after the period boundary, tick every 3 cycles and PWM period = 48 cycles. inc_freq_bt at div=0 keeps div=0.
- Assert rst_n=0 for 1 cycle mid-period with duty ch0=8 -> next cycle pwm_out=0, sel_ch=0; all duties and div return to 0.
